// File: rtl/hough_peak_select.sv
// Peak selector for the Hough accumulator readout: tracks the strongest left-lane
// (theta > split) and right-lane (theta < split) line across one full sweep.
module hough_peak_select #(
   parameter int THETA_UNROLL     = 16,
   parameter int ACCUM_BUFF_WIDTH = 8,
   parameter int THETA_BITS       = 9,
   parameter int RHO_BITS         = 12,
   parameter int RHOS             = 1179,
   parameter int START_THETA      = 20,
   parameter int THETAS           = 160,
   parameter int SPLIT_THETA      = 90
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic                                     in_valid,
   input  logic                                     in_last,
   input  logic [RHO_BITS-1:0]                      in_rho_idx,
   input  logic [THETA_BITS-1:0]                    in_theta_base,
   input  logic [THETA_UNROLL*ACCUM_BUFF_WIDTH-1:0] in_data,
   output logic [15:0]                              left_rho_out,
   output logic [15:0]                              right_rho_out,
   output logic [THETA_BITS-1:0]                    left_theta_out,
   output logic [THETA_BITS-1:0]                    right_theta_out,
   output logic                                     left_found,
   output logic                                     right_found,
   output logic                                     busy,
   output logic                                     done,
   output logic [1:0]                               dbg_state
);

   localparam int W  = ACCUM_BUFF_WIDTH;
   localparam int TW = THETA_BITS + 1;
   localparam logic [TW-1:0] C_START = TW'(START_THETA);
   localparam logic [TW-1:0] C_END   = TW'(THETAS);
   localparam logic [TW-1:0] C_SPLIT = TW'(SPLIT_THETA);
   localparam logic [15:0]   C_RHOS  = 16'(RHOS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: a beat is taken on any rising edge where in_valid is high, the
   // block is in RUN and start is low; there is no ready, the source never stalls.
   state_t r_state, w_state_next;

   logic                  w_accept;
   logic                  w_s1_live;
   logic [W-1:0]          w_l_cnt, w_r_cnt;
   logic [THETA_BITS-1:0] w_l_theta, w_r_theta;

   logic                  r_s1_valid, r_s1_last;
   logic [RHO_BITS-1:0]   r_s1_rho;
   logic [W-1:0]          r_s1_l_cnt, r_s1_r_cnt;
   logic [THETA_BITS-1:0] r_s1_l_theta, r_s1_r_theta;

   logic [W-1:0]          r_best_l_cnt, r_best_r_cnt;
   logic [THETA_BITS-1:0] r_best_l_theta, r_best_r_theta;
   logic [15:0]           r_best_l_rho, r_best_r_rho;

   assign w_accept  = (r_state == S_RUN) && in_valid && !start;
   assign w_s1_live = r_s1_valid && (r_state == S_RUN) && !start;

   // Per-side max over eligible lanes; strict compare keeps the lowest lane on ties.
   always_comb begin
      logic [TW-1:0] w_theta_k;
      logic [W-1:0]  w_vote_k;
      w_l_cnt   = '0;
      w_l_theta = '0;
      w_r_cnt   = '0;
      w_r_theta = '0;
      w_theta_k = '0;
      w_vote_k  = '0;
      for (int k = 0; k < THETA_UNROLL; k++) begin
         w_theta_k = TW'(in_theta_base) + TW'(k);
         w_vote_k  = in_data[k*W +: W];
         if (w_theta_k >= C_START && w_theta_k < C_END) begin
            if (w_theta_k > C_SPLIT && w_vote_k > w_l_cnt) begin
               w_l_cnt   = w_vote_k;
               w_l_theta = THETA_BITS'(w_theta_k);
            end
            if (w_theta_k < C_SPLIT && w_vote_k > w_r_cnt) begin
               w_r_cnt   = w_vote_k;
               w_r_theta = THETA_BITS'(w_theta_k);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_s1_rho     <= '0;
         r_s1_l_cnt   <= '0;
         r_s1_l_theta <= '0;
         r_s1_r_cnt   <= '0;
         r_s1_r_theta <= '0;
      end else if (start) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         r_s1_last  <= w_accept && in_last;
         if (w_accept) begin
            r_s1_rho     <= in_rho_idx;
            r_s1_l_cnt   <= w_l_cnt;
            r_s1_l_theta <= w_l_theta;
            r_s1_r_cnt   <= w_r_cnt;
            r_s1_r_theta <= w_r_theta;
         end
      end
   end

   // Running maxima: only a strictly larger count replaces, so zero never wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_best_l_cnt   <= '0;
         r_best_l_theta <= '0;
         r_best_l_rho   <= '0;
         r_best_r_cnt   <= '0;
         r_best_r_theta <= '0;
         r_best_r_rho   <= '0;
      end else if (start) begin
         r_best_l_cnt   <= '0;
         r_best_l_theta <= '0;
         r_best_l_rho   <= '0;
         r_best_r_cnt   <= '0;
         r_best_r_theta <= '0;
         r_best_r_rho   <= '0;
      end else if (w_s1_live) begin
         if (r_s1_l_cnt > r_best_l_cnt) begin
            r_best_l_cnt   <= r_s1_l_cnt;
            r_best_l_theta <= r_s1_l_theta;
            r_best_l_rho   <= 16'(r_s1_rho) - C_RHOS;
         end
         if (r_s1_r_cnt > r_best_r_cnt) begin
            r_best_r_cnt   <= r_s1_r_cnt;
            r_best_r_theta <= r_s1_r_theta;
            r_best_r_rho   <= 16'(r_s1_rho) - C_RHOS;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN: begin
            if (start)                       w_state_next = S_RUN;
            else if (w_s1_live && r_s1_last) w_state_next = S_DONE;
         end
         S_DONE:  if (start) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = (r_state == S_RUN);
      done            = (r_state == S_DONE);
      dbg_state       = r_state;
      left_rho_out    = r_best_l_rho;
      right_rho_out   = r_best_r_rho;
      left_theta_out  = r_best_l_theta;
      right_theta_out = r_best_r_theta;
      left_found      = (r_best_l_cnt != '0);
      right_found     = (r_best_r_cnt != '0);
   end

endmodule

// File: tb/tb_hough_peak_select.sv
// Directed bench for hough_peak_select: table of short sweeps plus hand-written
// sequences for the full zero sweep, mid-sweep reset and restart while done.
module tb_hough_peak_select;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic [11:0]  in_rho_idx = '0;
   logic [8:0]   in_theta_base = '0;
   logic [127:0] in_data = '0;
   logic [15:0]  left_rho_out, right_rho_out;
   logic [8:0]   left_theta_out, right_theta_out;
   logic         left_found, right_found, busy, done;
   logic [1:0]   dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   hough_peak_select dut (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
      .in_last(in_last), .in_rho_idx(in_rho_idx), .in_theta_base(in_theta_base),
      .in_data(in_data), .left_rho_out(left_rho_out), .right_rho_out(right_rho_out),
      .left_theta_out(left_theta_out), .right_theta_out(right_theta_out),
      .left_found(left_found), .right_found(right_found), .busy(busy),
      .done(done), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      string            name;
      int               nb;
      logic [2:0][11:0]  rho;
      logic [2:0][8:0]   base;
      logic [2:0][127:0] data;
      logic [15:0]      l_rho;
      logic [8:0]       l_theta;
      logic             l_found;
      logic [15:0]      r_rho;
      logic [8:0]       r_theta;
      logic             r_found;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [127:0] lane(input int k, input logic [7:0] v);
      logic [127:0] d;
      d = '0;
      d[k*8 +: 8] = v;
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic last, input logic [11:0] rho, input logic [8:0] base,
                       input logic [127:0] data);
      in_valid = 1'b1;
      in_last = last;
      in_rho_idx = rho;
      in_theta_base = base;
      in_data = data;
      tick();
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".l_rho"}, 32'(left_rho_out), 32'(v.l_rho));
      check({tag, ".l_theta"}, 32'(left_theta_out), 32'(v.l_theta));
      check({tag, ".l_found"}, 32'(left_found), 32'(v.l_found));
      check({tag, ".r_rho"}, 32'(right_rho_out), 32'(v.r_rho));
      check({tag, ".r_theta"}, 32'(right_theta_out), 32'(v.r_theta));
      check({tag, ".r_found"}, 32'(right_found), 32'(v.r_found));
   endtask

   task automatic set_vec(input int i, input string name, input int nb,
                          input logic [15:0] lr, input logic [8:0] lt, input logic lf,
                          input logic [15:0] rr, input logic [8:0] rt, input logic rf);
      vecs[i].name = name;  vecs[i].nb = nb;
      vecs[i].l_rho = lr;   vecs[i].l_theta = lt; vecs[i].l_found = lf;
      vecs[i].r_rho = rr;   vecs[i].r_theta = rt; vecs[i].r_found = rf;
      vecs[i].rho = '0;     vecs[i].base = '0;    vecs[i].data = '0;
   endtask

   initial begin
      vec_t z;
      // Two single votes, one per side.
      set_vec(0, "single", 2, 16'hFF5D, 9'd128, 1'b1, 16'h023F, 9'd60, 1'b1);
      vecs[0].rho[0] = 12'd1016; vecs[0].base[0] = 9'd116; vecs[0].data[0] = lane(12, 8'd200);
      vecs[0].rho[1] = 12'd1754; vecs[0].base[1] = 9'd52;  vecs[0].data[1] = lane(8, 8'd150);
      // Equal counts across rows: earliest row wins.
      set_vec(1, "rowtie", 3, 16'hFB6F, 9'd100, 1'b1, 16'h0000, 9'd0, 1'b0);
      vecs[1].rho[0] = 12'd10; vecs[1].base[0] = 9'd100; vecs[1].data[0] = lane(0, 8'd50);
      vecs[1].rho[1] = 12'd20; vecs[1].base[1] = 9'd100; vecs[1].data[1] = lane(0, 8'd50);
      vecs[1].rho[2] = 12'd30; vecs[1].base[2] = 9'd120; vecs[1].data[2] = lane(0, 8'd50) | lane(10, 8'd50);
      // Equal counts within one beat: lowest theta wins.
      set_vec(2, "lanetie", 1, 16'hFB83, 9'd120, 1'b1, 16'h0000, 9'd0, 1'b0);
      vecs[2].rho[0] = 12'd30; vecs[2].base[0] = 9'd120; vecs[2].data[0] = lane(0, 8'd50) | lane(10, 8'd50);
      // Split theta, below start, at/above end: all ignored.
      set_vec(3, "ignored", 3, 16'h0000, 9'd0, 1'b0, 16'h0000, 9'd0, 1'b0);
      vecs[3].rho[0] = 12'd500; vecs[3].base[0] = 9'd80;  vecs[3].data[0] = lane(10, 8'd255);
      vecs[3].rho[1] = 12'd500; vecs[3].base[1] = 9'd4;   vecs[3].data[1] = lane(15, 8'd255);
      vecs[3].rho[2] = 12'd500; vecs[3].base[2] = 9'd160; vecs[3].data[2] = lane(5, 8'd255);
      // Extreme thetas and rhos; smaller later vote does not replace.
      set_vec(4, "edges", 3, 16'h049A, 9'd159, 1'b1, 16'hFB65, 9'd20, 1'b1);
      vecs[4].rho[0] = 12'd0;    vecs[4].base[0] = 9'd5;   vecs[4].data[0] = lane(15, 8'd7);
      vecs[4].rho[1] = 12'd2357; vecs[4].base[1] = 9'd150; vecs[4].data[1] = lane(9, 8'd255);
      vecs[4].rho[2] = 12'd5;    vecs[4].base[2] = 9'd80;  vecs[4].data[2] = lane(9, 8'd6);
      // Beat straddling the split: 89 right, 90 dropped, 91 left.
      set_vec(5, "split", 1, 16'h0000, 9'd91, 1'b1, 16'h0000, 9'd89, 1'b1);
      vecs[5].rho[0] = 12'd1179; vecs[5].base[0] = 9'd88;
      vecs[5].data[0] = lane(1, 8'd30) | lane(2, 8'd255) | lane(3, 8'd40);
      // Strictly larger later vote replaces.
      set_vec(6, "greater", 2, 16'h0000, 9'd0, 1'b0, 16'hFB6B, 9'd21, 1'b1);
      vecs[6].rho[0] = 12'd5; vecs[6].base[0] = 9'd20; vecs[6].data[0] = lane(0, 8'd100);
      vecs[6].rho[1] = 12'd6; vecs[6].base[1] = 9'd20; vecs[6].data[1] = lane(1, 8'd101);

      // Reset state.
      repeat (3) tick();
      check("rst.state", 32'(dbg_state), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.l_rho", 32'(left_rho_out), 32'd0);
      reset = 1'b0;
      tick();

      // Full all-zero sweep.
      do_start();
      check("zero.busy", 32'(busy), 32'd1);
      for (int r = 0; r < 2358; r++)
         for (int b = 0; b < 9; b++)
            beat((r == 2357) && (b == 8), 12'(r), 9'(20 + 16 * b), '0);
      check("zero.done_early", 32'(done), 32'd0);
      tick();
      z = vecs[3];
      check_result("zero", z);
      check("zero.busy_end", 32'(busy), 32'd0);

      // Table of short sweeps.
      for (int i = 0; i < 7; i++) begin
         do_start();
         check({vecs[i].name, ".done_clr"}, 32'(done), 32'd0);
         for (int j = 0; j < vecs[i].nb; j++)
            beat(j == vecs[i].nb - 1, vecs[i].rho[j], vecs[i].base[j], vecs[i].data[j]);
         check({vecs[i].name, ".done_early"}, 32'(done), 32'd0);
         tick();
         check_result(vecs[i].name, vecs[i]);
      end

      // Beats while done are ignored.
      beat(1'b1, 12'd7, 9'd20, lane(10, 8'd255));
      tick();
      check("donebeat.r_rho", 32'(right_rho_out), 32'hFB6B);
      check("donebeat.r_theta", 32'(right_theta_out), 32'd21);

      // Mid-sweep reset.
      do_start();
      beat(1'b0, 12'd100, 9'd20, lane(0, 8'd99));
      tick();
      check("midrst.r_found_pre", 32'(right_found), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst.r_found", 32'(right_found), 32'd0);
      check("midrst.r_rho", 32'(right_rho_out), 32'd0);
      check("midrst.state", 32'(dbg_state), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      do_start();
      beat(1'b1, 12'd200, 9'd36, lane(4, 8'd10));
      tick();
      z = vecs[3];
      z.r_rho = 16'hFC2D; z.r_theta = 9'd40; z.r_found = 1'b1;
      check_result("postrst", z);

      // Restart while done, with a beat in the start cycle.
      start = 1'b1;
      beat(1'b1, 12'd300, 9'd36, lane(4, 8'd250));
      start = 1'b0;
      check("restart.done", 32'(done), 32'd0);
      check("restart.busy", 32'(busy), 32'd1);
      tick();
      check("restart.still_run", 32'(done), 32'd0);
      beat(1'b1, 12'd400, 9'd100, lane(0, 8'd5));
      tick();
      z = vecs[3];
      z.l_rho = 16'hFCF5; z.l_theta = 9'd100; z.l_found = 1'b1;
      check_result("restart", z);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/hough_peak_select.md
Name: hough_peak_select

Overview:
- Consumes the accumulator-buffer readout stream of the Hough stage: one rho row per burst, THETA_UNROLL vote counts per beat.
- Tracks the strongest left-lane line (theta > 90) and right-lane line (theta < 90) with running maxima.
- Outputs the winning signed rho and theta for each side once the last beat is consumed.
- Sits directly downstream of the accumulator buffer inside hough_top and drives left/right rho/theta outputs and hough_done.

Parameters:
THETA_UNROLL, 16, vote counts per beat (lanes)
ACCUM_BUFF_WIDTH, 8, bits per vote count
THETA_BITS, 9, theta index width
RHO_BITS, 12, rho index width (unsigned row index)
RHOS, 1179, offset subtracted from rho index to form signed rho
START_THETA, 20, first valid theta
THETAS, 160, exclusive upper theta bound
SPLIT_THETA, 90, boundary; theta > SPLIT is left, theta < SPLIT is right, theta == SPLIT ignored

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; clears running maxima, arms block
in_valid  in  1  beat valid
in_last  in  1  final beat of whole accumulator sweep (qualified by in_valid)
in_rho_idx  in  RHO_BITS  row index 0..2*RHOS-1
in_theta_base  in  THETA_BITS  theta of lane 0
in_data  in  THETA_UNROLL*ACCUM_BUFF_WIDTH  lane k = bits [k*W +: W], theta = base+k
left_rho_out  out  16  signed rho of left winner
right_rho_out  out  16  signed rho of right winner
left_theta_out  out  THETA_BITS  left winner theta
right_theta_out  out  THETA_BITS  right winner theta
left_found  out  1  left winner has nonzero votes
right_found  out  1  right winner has nonzero votes
busy  out  1  armed, sweep in progress
done  out  1  level; high from result-valid until next start

Behaviour:
- Reset: all outputs 0; state IDLE; best counts 0.
- States: IDLE -> (start) RUN -> (last beat retired from pipeline) DONE -> (start) RUN. start in RUN or DONE restarts: maxima cleared, in-flight beats discarded, done drops next cycle.
- Beats with in_valid while IDLE or DONE are ignored. No backpressure: block accepts one beat per cycle in RUN.
- Stage 1 (registered): lane k eligible if START_THETA <= base+k < THETAS and base+k != SPLIT_THETA. Ineligible lanes count as 0. Independent reduction trees pick max eligible left lane and max eligible right lane. Ties go to the lowest lane index (lowest theta). Register count, theta, rho_idx, valid, last.
- Stage 2 (registered): replace running best only if new count is strictly greater (earlier rho / earlier beat wins ties). A zero count never replaces.
- Signed rho = rho_idx - RHOS, computed in 16-bit two's complement when stored.
- Latency: done and outputs valid 2 cycles after the in_last beat is sampled. Outputs are stable while done is high.
- left_found/right_found are 0 if no nonzero eligible vote was seen; the corresponding rho/theta then remain 0.
- Count widths are compared unsigned. Saturation is not applied; max count is 2^W-1.
- Reset mid-sweep: immediate return to IDLE with all outputs 0.
- start and in_valid in the same cycle: the beat is ignored; the sweep begins next cycle.

Test Plan:
1. Reset, start, sweep of all-zero rows (rho 0..2357, bases 20,36,...,148, in_last on final beat) -> done high 2 cycles later; left_found=right_found=0; all rho/theta 0.
2. Single vote 200 at rho_idx 1016, theta 128; single vote 150 at rho_idx 1754, theta 60 -> left_rho_out=-163, left_theta_out=128, right_rho_out=575, right_theta_out=60; both found=1.
3. Equal count 50 at (rho_idx 10, theta 100) and (rho_idx 20, theta 100); also lanes theta 120 and 130 both 50 in one beat -> left winner is rho_idx 10 (-1169), theta 100.
4. Vote 255 at theta 90, at theta 19 (base 4), and at theta 165 (base 160) -> all ignored; found flags stay 0.
5. Assert reset at mid-sweep after a 99-vote beat -> outputs 0 immediately. Then start and a clean sweep with a 10-vote beat at theta 40 -> right winner count source is 10, not 99.
6. Assert start while done is high -> done drops next cycle. A beat with in_valid in the same cycle as start is ignored. The second sweep results are independent of the first.
